holy_axi_ram_slave: RTL and testbench
=====================================

Name: holy_axi_ram_slave

Overview:
- AXI4 slave memory model/on-chip RAM that sits directly downstream of the core's AXI master port.
- Consumes the core's instruction and data cache refill and writeback bursts.
- Used as the memory endpoint in simulation benches and as a small BRAM in FPGA builds.
- Independent read and write engines share one byte-enabled word array.

Parameters:
- MEM_WORDS, 4096, number of 32-bit words; byte span = MEM_WORDS*4.
- BASE_ADDR, 32'h0000_0000, byte address of word 0.
- INIT_FILE, "", hex file loaded into the array at elaboration when non-empty.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- s_axi_awid  in  4  write ID.
- s_axi_awaddr  in  32  write start byte address.
- s_axi_awlen  in  8  beats-1.
- s_axi_awsize  in  3  beat size.
- s_axi_awburst  in  2  burst type.
- s_axi_awvalid  in  1  AW valid.
- s_axi_awready  out  1  AW ready.
- s_axi_wdata  in  32  write data.
- s_axi_wstrb  in  4  byte enables.
- s_axi_wlast  in  1  last write beat.
- s_axi_wvalid  in  1  W valid.
- s_axi_wready  out  1  W ready.
- s_axi_bid  out  4  response ID.
- s_axi_bresp  out  2  write response.
- s_axi_bvalid  out  1  B valid.
- s_axi_bready  in  1  B ready.
- s_axi_arid  in  4  read ID.
- s_axi_araddr  in  32  read start byte address.
- s_axi_arlen  in  8  beats-1.
- s_axi_arsize  in  3  beat size.
- s_axi_arburst  in  2  burst type.
- s_axi_arvalid  in  1  AR valid.
- s_axi_arready  out  1  AR ready.
- s_axi_rid  out  4  read ID.
- s_axi_rdata  out  32  read data.
- s_axi_rresp  out  2  read response.
- s_axi_rlast  out  1  last read beat.
- s_axi_rvalid  out  1  R valid.
- s_axi_rready  in  1  R ready.

Behaviour:
- Reset: all outputs 0 except arready=1 and awready=1. Both FSMs go to IDLE. An in-flight burst is dropped with no response. Array contents are preserved.
- Word index = (addr-BASE_ADDR)>>2. An index is in range only if addr>=BASE_ADDR and index<MEM_WORDS. The low 2 address bits are ignored.
- Every burst type is addressed as INCR: +4 per beat, with no 4 KiB boundary check.
- A transaction with size!=3'b010 or burst!=2'b01 is still executed as word INCR but reports SLVERR (2'b10).
- Read FSM, R_IDLE -> R_BURST:
  - R_IDLE: arready=1. On AR handshake, latch id/len/addr. In the next cycle, rvalid=1 and rdata=mem[start], rlast=(len==0).
  - R_BURST: rvalid, rdata, rid, rresp and rlast hold stable while rready=0.
  - On R handshake with rlast=0, load the next beat in the following cycle. Back-to-back beats are allowed, so throughput is 1 beat/cycle.
  - On R handshake with rlast=1, go to R_IDLE with rvalid=0 and arready=1 in the next cycle.
  - Per-beat rresp: an out-of-range beat returns rdata=0 and SLVERR; otherwise OKAY, or SLVERR for an unsupported size/burst.
- Write FSM, W_IDLE -> W_DATA -> W_RESP:
  - W_IDLE: awready=1, wready=0. On AW handshake, latch id/len/addr and clear the beat count; go to W_DATA.
  - W_DATA: wready=1. On each W handshake, write the bytes where wstrb is set; an out-of-range beat is not written. The beat count increments.
  - The burst ends on the handshake where count==awlen, independent of wlast. Then go to W_RESP.
  - bresp is sticky SLVERR if any of these occurred: an out-of-range beat, an unsupported size/burst, wlast=1 with count<awlen, or wlast=0 on the final beat.
  - W_RESP: bvalid=1 with bid=latched ID, held until bready. Go to W_IDLE the cycle after the B handshake.
  - W beats presented before the AW handshake are not accepted (wready=0).
- Read and write run concurrently. A read and write of the same word in the same cycle returns the old value; the write lands.
- Array read latency is 1 cycle (registered).

Decomposition:
- holy_axi_pkg: resp constants OKAY=2'b00 and SLVERR=2'b10; burst constants FIXED/INCR/WRAP; SIZE_WORD=3'b010; read_state_t and write_state_t enums.
- Sub-module holy_byte_ram: MEM_WORDS x 32 array, one write port with 4-bit byte enable, one registered read port, and INIT_FILE load.

Test Plan:
- Single write then read: AW addr 0x10, len 0, wdata 0xDEADBEEF, wstrb 4'hF, then AR 0x10 -> bresp 00; rdata 0xDEADBEEF, rlast=1, rresp 00.
- Burst read with backpressure: preload words 0..15 = index*0x11111111 mod 2^32; AR 0x0 len 15 id 4'h3; rready toggles every cycle -> 16 beats in order, rid=3, rlast only on beat 16, data stable while stalled.
- Byte strobes: word 0x20=0x00000000, write 0xAABBCCDD with wstrb 4'b0101 -> read returns 0x00BB00DD.
- Out of range: AR at BASE_ADDR+MEM_WORDS*4 len 1 -> 2 beats with rdata 0 and rresp 10. A write there gives bresp 10 and the array is unchanged.
- wlast mismatch: AW len 3, wlast asserted on beat 2 -> all 4 beats accepted and written, bresp 10.
- Reset mid-burst: assert rst during beat 5 of a len 7 read -> the next cycle rvalid=0 and arready=1; previously written data is still readable.

Source files
------------

// File: rtl/holy_axi_ram_slave_pkg.sv
// Shared AXI constants, FSM state types and transaction-check helper for the
// holy_axi_ram_slave memory endpoint.
package holy_axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [2:0] SIZE_WORD = 3'b010;

  typedef enum logic {
    R_IDLE,
    R_BURST
  } read_state_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } write_state_t;

  // Anything other than a 32-bit INCR burst is still executed, but flagged.
  function automatic logic cfg_err(input logic [2:0] size, input logic [1:0] burst);
    return (size != SIZE_WORD) || (burst != BURST_INCR);
  endfunction

endpackage

// File: rtl/holy_axi_ram_slave_if.sv
// AXI4 channel bundle between the core's master port and the RAM slave.
interface holy_axi_if;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
    output wdata, wstrb, wlast, wvalid, input wready,
    input bid, bresp, bvalid, output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
    input rid, rdata, rresp, rlast, rvalid, output rready
  );

  modport slave (
    input awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
    input wdata, wstrb, wlast, wvalid, output wready,
    output bid, bresp, bvalid, input bready,
    input arid, araddr, arlen, arsize, arburst, arvalid, output arready,
    output rid, rdata, rresp, rlast, rvalid, input rready
  );
endinterface

// File: rtl/holy_axi_ram_slave_byte_ram.sv
// Byte-enabled word array: one write port, one registered read port that
// returns zero for addresses the caller has flagged as out of range.
module holy_byte_ram #(
  parameter int    MEM_WORDS = 4096,
  parameter int    AW        = 12,
  parameter string INIT_FILE = ""
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [3:0]    wstrb,
  input  logic [31:0]   wdata,
  input  logic          re,
  input  logic          rok,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem_r [MEM_WORDS];

  // Byte-lane writes; contents survive reset, only the write is suppressed.
  always_ff @(posedge clk) begin
    if (we && !rst) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) mem_r[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // Registered read, updated only when a new beat is requested.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= 32'h0000_0000;
    end else if (re) begin
      rdata <= rok ? mem_r[raddr] : 32'h0000_0000;
    end
  end

endmodule

// File: rtl/holy_axi_ram_slave.sv
// AXI4 RAM slave: independent read and write burst engines over one
// byte-enabled word array; every burst is addressed as word INCR.
module holy_axi_ram_slave
  import holy_axi_pkg::*;
#(
  parameter int          MEM_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter string       INIT_FILE = ""
) (
  input logic       clk,
  input logic       rst,
  holy_axi_if.slave s_axi
);

  localparam int          AW          = $clog2(MEM_WORDS);
  localparam logic [31:0] MEM_WORDS_W = 32'(MEM_WORDS);

  read_state_t  r_state_r;
  logic         ar_ready_r, r_valid_r, r_last_r, r_cfg_err_r;
  logic [3:0]   r_id_r;
  logic [1:0]   r_resp_r;
  logic [7:0]   r_len_r, r_cnt_r;
  logic [31:0]  r_addr_r;

  write_state_t w_state_r;
  logic         aw_ready_r, w_ready_r, b_valid_r, w_err_r;
  logic [3:0]   w_id_r, b_id_r;
  logic [1:0]   b_resp_r;
  logic [7:0]   w_len_r, w_cnt_r;
  logic [31:0]  w_addr_r;

  logic         ar_hs_s, r_hs_s, aw_hs_s, w_hs_s;
  logic         rd_en_s, rd_ok_s, rd_cfg_err_s, wr_ok_s, we_s;
  logic         w_last_beat_s, w_beat_err_s;
  logic [1:0]   rd_resp_s;
  logic [31:0]  rd_addr_s, rd_word_s, wr_word_s, ram_rdata_s;

  assign ar_hs_s = s_axi.arvalid & ar_ready_r;
  assign r_hs_s  = r_valid_r & s_axi.rready;
  assign aw_hs_s = s_axi.awvalid & aw_ready_r;
  assign w_hs_s  = s_axi.wvalid & w_ready_r;

  assign rd_word_s = (rd_addr_s - BASE_ADDR) >> 2;
  assign rd_ok_s   = (rd_addr_s >= BASE_ADDR) && (rd_word_s < MEM_WORDS_W);
  assign wr_word_s = (w_addr_r - BASE_ADDR) >> 2;
  assign wr_ok_s   = (w_addr_r >= BASE_ADDR) && (wr_word_s < MEM_WORDS_W);
  assign we_s      = w_hs_s & wr_ok_s;

  assign w_last_beat_s = (w_cnt_r == w_len_r);
  assign w_beat_err_s  = ~wr_ok_s | (s_axi.wlast & ~w_last_beat_s) | (~s_axi.wlast & w_last_beat_s);

  // Pick the address of the beat the RAM must fetch this cycle, and its response.
  always_comb begin
    rd_en_s      = 1'b0;
    rd_addr_s    = r_addr_r;
    rd_cfg_err_s = r_cfg_err_r;
    case (r_state_r)
      R_IDLE: begin
        rd_en_s      = ar_hs_s;
        rd_addr_s    = s_axi.araddr;
        rd_cfg_err_s = cfg_err(s_axi.arsize, s_axi.arburst);
      end
      R_BURST: rd_en_s = r_hs_s & ~r_last_r;
      default: rd_en_s = 1'b0;
    endcase
    if (rd_ok_s && !rd_cfg_err_s) rd_resp_s = RESP_OKAY;
    else                          rd_resp_s = RESP_SLVERR;
  end

  // Read engine: one beat per cycle, all R outputs frozen while rready is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_r   <= R_IDLE;
      ar_ready_r  <= 1'b1;
      r_valid_r   <= 1'b0;
      r_last_r    <= 1'b0;
      r_id_r      <= 4'h0;
      r_resp_r    <= RESP_OKAY;
      r_len_r     <= 8'd0;
      r_cnt_r     <= 8'd0;
      r_addr_r    <= 32'h0000_0000;
      r_cfg_err_r <= 1'b0;
    end else begin
      case (r_state_r)
        R_IDLE: begin
          if (ar_hs_s) begin
            r_state_r   <= R_BURST;
            ar_ready_r  <= 1'b0;
            r_valid_r   <= 1'b1;
            r_last_r    <= (s_axi.arlen == 8'd0);
            r_id_r      <= s_axi.arid;
            r_resp_r    <= rd_resp_s;
            r_len_r     <= s_axi.arlen;
            r_cnt_r     <= 8'd0;
            r_addr_r    <= s_axi.araddr + 32'd4;
            r_cfg_err_r <= rd_cfg_err_s;
          end
        end
        R_BURST: begin
          if (r_hs_s && r_last_r) begin
            r_state_r  <= R_IDLE;
            ar_ready_r <= 1'b1;
            r_valid_r  <= 1'b0;
            r_last_r   <= 1'b0;
          end else if (r_hs_s) begin
            r_resp_r <= rd_resp_s;
            r_last_r <= ((r_cnt_r + 8'd1) == r_len_r);
            r_cnt_r  <= r_cnt_r + 8'd1;
            r_addr_r <= r_addr_r + 32'd4;
          end
        end
        default: begin
          r_state_r  <= R_IDLE;
          ar_ready_r <= 1'b1;
          r_valid_r  <= 1'b0;
        end
      endcase
    end
  end

  // Write engine: beat count alone ends the burst; wlast only feeds the error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_r  <= W_IDLE;
      aw_ready_r <= 1'b1;
      w_ready_r  <= 1'b0;
      b_valid_r  <= 1'b0;
      b_id_r     <= 4'h0;
      b_resp_r   <= RESP_OKAY;
      w_id_r     <= 4'h0;
      w_len_r    <= 8'd0;
      w_cnt_r    <= 8'd0;
      w_addr_r   <= 32'h0000_0000;
      w_err_r    <= 1'b0;
    end else begin
      case (w_state_r)
        W_IDLE: begin
          if (aw_hs_s) begin
            w_state_r  <= W_DATA;
            aw_ready_r <= 1'b0;
            w_ready_r  <= 1'b1;
            w_id_r     <= s_axi.awid;
            w_len_r    <= s_axi.awlen;
            w_cnt_r    <= 8'd0;
            w_addr_r   <= s_axi.awaddr;
            w_err_r    <= cfg_err(s_axi.awsize, s_axi.awburst);
          end
        end
        W_DATA: begin
          if (w_hs_s) begin
            w_addr_r <= w_addr_r + 32'd4;
            w_cnt_r  <= w_cnt_r + 8'd1;
            w_err_r  <= w_err_r | w_beat_err_s;
            if (w_last_beat_s) begin
              w_state_r <= W_RESP;
              w_ready_r <= 1'b0;
              b_valid_r <= 1'b1;
              b_id_r    <= w_id_r;
              b_resp_r  <= (w_err_r | w_beat_err_s) ? RESP_SLVERR : RESP_OKAY;
            end
          end
        end
        W_RESP: begin
          if (s_axi.bready) begin
            w_state_r  <= W_IDLE;
            b_valid_r  <= 1'b0;
            aw_ready_r <= 1'b1;
          end
        end
        default: begin
          w_state_r  <= W_IDLE;
          aw_ready_r <= 1'b1;
          w_ready_r  <= 1'b0;
          b_valid_r  <= 1'b0;
        end
      endcase
    end
  end

  holy_byte_ram #(
    .MEM_WORDS (MEM_WORDS),
    .AW        (AW),
    .INIT_FILE (INIT_FILE)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (we_s),
    .waddr (wr_word_s[AW-1:0]),
    .wstrb (s_axi.wstrb),
    .wdata (s_axi.wdata),
    .re    (rd_en_s),
    .rok   (rd_ok_s),
    .raddr (rd_word_s[AW-1:0]),
    .rdata (ram_rdata_s)
  );

  assign s_axi.arready = ar_ready_r;
  assign s_axi.rvalid  = r_valid_r;
  assign s_axi.rlast   = r_last_r;
  assign s_axi.rid     = r_id_r;
  assign s_axi.rresp   = r_resp_r;
  assign s_axi.rdata   = ram_rdata_s;
  assign s_axi.awready = aw_ready_r;
  assign s_axi.wready  = w_ready_r;
  assign s_axi.bvalid  = b_valid_r;
  assign s_axi.bid     = b_id_r;
  assign s_axi.bresp   = b_resp_r;

endmodule

// File: tb/tb_holy_axi_ram_slave.sv
// Self-checking bench for holy_axi_ram_slave: directed vector table, burst
// corner sequences and random traffic against a word-array reference model.
module tb_holy_axi_ram_slave;
  import holy_axi_pkg::*;

  localparam int          MEMW   = 256;
  localparam logic [31:0] BASE   = 32'h0000_0000;
  localparam logic [31:0] MEMW_W = 32'(MEMW);
  localparam int          TMO    = 300;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  holy_axi_if axi ();

  holy_axi_ram_slave #(.MEM_WORDS(MEMW), .BASE_ADDR(BASE), .INIT_FILE("")) dut (
    .clk   (clk),
    .rst   (rst),
    .s_axi (axi)
  );

  int tests = 0;
  int fails = 0;

  logic [31:0] ref_mem [MEMW];
  logic [31:0] wdat [256];
  logic [3:0]  wstb [256];
  logic [31:0] rdat [256];
  logic [1:0]  rrsp [256];
  logic        rlst [256];
  logic [3:0]  rids [256];
  int          rcount;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    tests++;
    fails++;
    $display("FAIL %s: no handshake within %0d cycles", nm, TMO);
  endtask

  function automatic bit ref_ok(input logic [31:0] a);
    return (a >= BASE) && (((a - BASE) >> 2) < MEMW_W);
  endfunction

  function automatic int ref_idx(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  // Applies a write burst from wdat/wstb to the model and returns the expected bresp.
  function automatic logic [1:0] model_write(input logic [31:0] addr, input int len,
                                             input logic [2:0] size, input logic [1:0] burst,
                                             input int wlast_at);
    bit err = (size != SIZE_WORD) || (burst != BURST_INCR);
    for (int i = 0; i <= len; i++) begin
      logic [31:0] a = addr + 32'(4 * i);
      bit lst = (wlast_at < 0) ? (i == len) : (i == wlast_at);
      if (lst != (i == len)) err = 1'b1;
      if (!ref_ok(a)) err = 1'b1;
      else
        for (int b = 0; b < 4; b++)
          if (wstb[i][b]) ref_mem[ref_idx(a)][8*b +: 8] = wdat[i][8*b +: 8];
    end
    return err ? RESP_SLVERR : RESP_OKAY;
  endfunction

  task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input logic [3:0] id, input int wlast_at,
                          input int bdelay, output logic [1:0] resp, output logic [3:0] bid_o);
    int n;
    resp = 2'b11;
    bid_o = 4'h0;
    axi.awaddr = addr; axi.awlen = len; axi.awsize = size; axi.awburst = burst;
    axi.awid = id; axi.awvalid = 1'b1;
    n = 0;
    while (!axi.awready && n < TMO) begin @(negedge clk); n++; end
    @(negedge clk);
    axi.awvalid = 1'b0;
    if (n >= TMO) begin timeout("aw_handshake"); return; end
    for (int i = 0; i <= int'(len); i++) begin
      axi.wdata = wdat[i]; axi.wstrb = wstb[i];
      axi.wlast = (wlast_at < 0) ? (i == int'(len)) : (i == wlast_at);
      axi.wvalid = 1'b1;
      n = 0;
      while (!axi.wready && n < TMO) begin @(negedge clk); n++; end
      @(negedge clk);
      if (n >= TMO) begin axi.wvalid = 1'b0; timeout("w_handshake"); return; end
    end
    axi.wvalid = 1'b0;
    axi.wlast = 1'b0;
    n = 0;
    while (!axi.bvalid && n < TMO) begin @(negedge clk); n++; end
    if (n >= TMO) begin timeout("b_valid"); return; end
    for (int d = 0; d < bdelay; d++) begin
      @(negedge clk);
      check("bvalid_held", axi.bvalid, 1'b1);
    end
    resp = axi.bresp;
    bid_o = axi.bid;
    axi.bready = 1'b1;
    @(negedge clk);
    axi.bready = 1'b0;
    check("bvalid_after_b", axi.bvalid, 1'b0);
  endtask

  // mode 0: rready always high, 1: toggling starting low, 2: random.
  task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] burst, input logic [3:0] id, input int mode);
    int n;
    bit tog = 1'b0, stalled = 1'b0, first = 1'b1, rr;
    logic [31:0] h_data;
    logic [1:0]  h_resp;
    logic        h_last;
    rcount = 0;
    axi.araddr = addr; axi.arlen = len; axi.arsize = size; axi.arburst = burst;
    axi.arid = id; axi.arvalid = 1'b1;
    n = 0;
    while (!axi.arready && n < TMO) begin @(negedge clk); n++; end
    @(negedge clk);
    axi.arvalid = 1'b0;
    if (n >= TMO) begin timeout("ar_handshake"); return; end
    n = 0;
    while (rcount <= int'(len) && n < TMO) begin
      if (first) check("r_first_latency", axi.rvalid, 1'b1);
      first = 1'b0;
      if (stalled) begin
        check("r_hold_valid", axi.rvalid, 1'b1);
        check("r_hold_data", axi.rdata, h_data);
        check("r_hold_resp", axi.rresp, h_resp);
        check("r_hold_last", axi.rlast, h_last);
      end
      rr = (mode == 0) ? 1'b1 : (mode == 1) ? tog : 1'($urandom_range(0, 1));
      tog = ~tog;
      axi.rready = rr;
      stalled = 1'b0;
      if (axi.rvalid && rr) begin
        rdat[rcount] = axi.rdata; rrsp[rcount] = axi.rresp;
        rlst[rcount] = axi.rlast; rids[rcount] = axi.rid;
        rcount++;
      end else if (axi.rvalid) begin
        stalled = 1'b1;
        h_data = axi.rdata; h_resp = axi.rresp; h_last = axi.rlast;
      end
      @(negedge clk);
      n++;
    end
    axi.rready = 1'b0;
    if (rcount <= int'(len)) begin timeout("r_beats"); return; end
    check("rvalid_after_last", axi.rvalid, 1'b0);
    check("arready_after_last", axi.arready, 1'b1);
  endtask

  task automatic verify_read(input logic [31:0] addr, input int len, input logic [2:0] size,
                             input logic [1:0] burst, input logic [3:0] id);
    check("rd_beat_count", 32'(rcount), 32'(len + 1));
    for (int i = 0; i < rcount; i++) begin
      logic [31:0] a = addr + 32'(4 * i);
      bit ok = ref_ok(a);
      check("rd_data", rdat[i], ok ? ref_mem[ref_idx(a)] : 32'h0);
      check("rd_resp", rrsp[i], (ok && size == SIZE_WORD && burst == BURST_INCR) ? RESP_OKAY : RESP_SLVERR);
      check("rd_last", rlst[i], i == len);
      check("rd_id", rids[i], id);
    end
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [3:0]  id;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  exp_resp;
    logic [31:0] exp_data;
  } vec_t;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, expected $finish");
    $fatal(1);
  end

  initial begin
    vec_t        vecs[$];
    logic [1:0]  resp, mresp;
    logic [3:0]  bid_o;
    int          n;

    axi.awid = 4'h0; axi.awaddr = 32'h0; axi.awlen = 8'd0; axi.awsize = SIZE_WORD;
    axi.awburst = BURST_INCR; axi.awvalid = 1'b0; axi.wdata = 32'h0; axi.wstrb = 4'h0;
    axi.wlast = 1'b0; axi.wvalid = 1'b0; axi.bready = 1'b0; axi.arid = 4'h0;
    axi.araddr = 32'h0; axi.arlen = 8'd0; axi.arsize = SIZE_WORD; axi.arburst = BURST_INCR;
    axi.arvalid = 1'b0; axi.rready = 1'b0;

    vecs.push_back('{1'b1, 32'h10,  8'd0, SIZE_WORD, BURST_INCR,  4'h1, 32'hDEADBEEF, 4'hF, RESP_OKAY,   32'h0});
    vecs.push_back('{1'b0, 32'h10,  8'd0, SIZE_WORD, BURST_INCR,  4'h2, 32'h0,        4'h0, RESP_OKAY,   32'hDEADBEEF});
    vecs.push_back('{1'b1, 32'h20,  8'd0, SIZE_WORD, BURST_INCR,  4'h3, 32'h00000000, 4'hF, RESP_OKAY,   32'h0});
    vecs.push_back('{1'b1, 32'h20,  8'd0, SIZE_WORD, BURST_INCR,  4'h4, 32'hAABBCCDD, 4'h5, RESP_OKAY,   32'h0});
    vecs.push_back('{1'b0, 32'h20,  8'd0, SIZE_WORD, BURST_INCR,  4'h5, 32'h0,        4'h0, RESP_OKAY,   32'h00BB00DD});
    vecs.push_back('{1'b1, 32'h30,  8'd0, 3'b001,    BURST_INCR,  4'h6, 32'h12345678, 4'hF, RESP_SLVERR, 32'h0});
    vecs.push_back('{1'b0, 32'h30,  8'd0, SIZE_WORD, BURST_INCR,  4'h7, 32'h0,        4'h0, RESP_OKAY,   32'h12345678});
    vecs.push_back('{1'b0, 32'h30,  8'd0, SIZE_WORD, BURST_FIXED, 4'h8, 32'h0,        4'h0, RESP_SLVERR, 32'h12345678});
    vecs.push_back('{1'b0, 32'h30,  8'd0, SIZE_WORD, BURST_WRAP,  4'h9, 32'h0,        4'h0, RESP_SLVERR, 32'h12345678});
    vecs.push_back('{1'b1, 32'h400, 8'd0, SIZE_WORD, BURST_INCR,  4'hA, 32'hCAFEF00D, 4'hF, RESP_SLVERR, 32'h0});
    vecs.push_back('{1'b0, 32'h400, 8'd1, SIZE_WORD, BURST_INCR,  4'hB, 32'h0,        4'h0, RESP_SLVERR, 32'h0});
    vecs.push_back('{1'b0, 32'h0,   8'd0, SIZE_WORD, BURST_INCR,  4'hC, 32'h0,        4'h0, RESP_OKAY,   32'h0});
    vecs.push_back('{1'b1, 32'h3F8, 8'd1, SIZE_WORD, BURST_INCR,  4'hD, 32'h5A5A5A5A, 4'hF, RESP_OKAY,   32'h0});
    vecs.push_back('{1'b0, 32'h3F8, 8'd1, SIZE_WORD, BURST_INCR,  4'hE, 32'h0,        4'h0, RESP_OKAY,   32'h5A5A5A5A});
    vecs.push_back('{1'b1, 32'h3FC, 8'd1, SIZE_WORD, BURST_INCR,  4'hF, 32'h00000077, 4'hF, RESP_SLVERR, 32'h0});
    vecs.push_back('{1'b0, 32'h3FC, 8'd0, SIZE_WORD, BURST_INCR,  4'h1, 32'h0,        4'h0, RESP_OKAY,   32'h00000077});
    vecs.push_back('{1'b0, 32'h13,  8'd0, SIZE_WORD, BURST_INCR,  4'h2, 32'h0,        4'h0, RESP_OKAY,   32'hDEADBEEF});

    // Reset values, checked while reset is still held.
    repeat (3) @(negedge clk);
    check("rst_arready", axi.arready, 1'b1);
    check("rst_awready", axi.awready, 1'b1);
    check("rst_wready", axi.wready, 1'b0);
    check("rst_rvalid", axi.rvalid, 1'b0);
    check("rst_rlast", axi.rlast, 1'b0);
    check("rst_rdata", axi.rdata, 32'h0);
    check("rst_rid_rresp", {axi.rid, axi.rresp}, 6'h0);
    check("rst_bvalid", axi.bvalid, 1'b0);
    check("rst_bid_bresp", {axi.bid, axi.bresp}, 6'h0);
    rst = 1'b0;
    @(negedge clk);

    // W beats before any AW must be refused.
    axi.wvalid = 1'b1; axi.wdata = 32'hFFFFFFFF; axi.wstrb = 4'hF;
    repeat (2) begin @(negedge clk); check("wready_before_aw", axi.wready, 1'b0); end
    axi.wvalid = 1'b0;

    // Zero the whole array with one maximum-length burst.
    for (int i = 0; i < 256; i++) begin wdat[i] = 32'h0; wstb[i] = 4'hF; end
    mresp = model_write(32'h0, 255, SIZE_WORD, BURST_INCR, -1);
    do_write(32'h0, 8'd255, SIZE_WORD, BURST_INCR, 4'h0, -1, 0, resp, bid_o);
    check("zero_fill_bresp", resp, mresp);

    // Directed vector table.
    foreach (vecs[k]) begin
      if (vecs[k].wr) begin
        for (int i = 0; i <= int'(vecs[k].len); i++) begin wdat[i] = vecs[k].data; wstb[i] = vecs[k].strb; end
        mresp = model_write(vecs[k].addr, int'(vecs[k].len), vecs[k].size, vecs[k].burst, -1);
        do_write(vecs[k].addr, vecs[k].len, vecs[k].size, vecs[k].burst, vecs[k].id, -1, k % 3, resp, bid_o);
        check($sformatf("vec%0d_bresp", k), resp, vecs[k].exp_resp);
        check($sformatf("vec%0d_bid", k), bid_o, vecs[k].id);
      end else begin
        do_read(vecs[k].addr, vecs[k].len, vecs[k].size, vecs[k].burst, vecs[k].id, 0);
        check($sformatf("vec%0d_beats", k), 32'(rcount), 32'(vecs[k].len) + 32'd1);
        for (int i = 0; i < rcount; i++) begin
          check($sformatf("vec%0d_rdata", k), rdat[i], vecs[k].exp_data);
          check($sformatf("vec%0d_rresp", k), rrsp[i], vecs[k].exp_resp);
          check($sformatf("vec%0d_rlast", k), rlst[i], i == int'(vecs[k].len));
          check($sformatf("vec%0d_rid", k), rids[i], vecs[k].id);
        end
      end
    end

    // 16-beat read with rready toggling every cycle.
    for (int i = 0; i < 16; i++) begin wdat[i] = 32'(i) * 32'h11111111; wstb[i] = 4'hF; end
    mresp = model_write(32'h0, 15, SIZE_WORD, BURST_INCR, -1);
    do_write(32'h0, 8'd15, SIZE_WORD, BURST_INCR, 4'h3, -1, 1, resp, bid_o);
    check("preload_bresp", resp, RESP_OKAY);
    do_read(32'h0, 8'd15, SIZE_WORD, BURST_INCR, 4'h3, 1);
    for (int i = 0; i < rcount; i++) check("bp_rdata", rdat[i], 32'(i) * 32'h11111111);
    verify_read(32'h0, 15, SIZE_WORD, BURST_INCR, 4'h3);

    // Early wlast: every beat still written, response flagged.
    for (int i = 0; i < 4; i++) begin wdat[i] = 32'hC0DE0000 + 32'(i); wstb[i] = 4'hF; end
    mresp = model_write(32'h100, 3, SIZE_WORD, BURST_INCR, 1);
    do_write(32'h100, 8'd3, SIZE_WORD, BURST_INCR, 4'h6, 1, 0, resp, bid_o);
    check("early_wlast_bresp", resp, RESP_SLVERR);
    do_read(32'h100, 8'd3, SIZE_WORD, BURST_INCR, 4'h6, 0);
    for (int i = 0; i < rcount; i++) check("early_wlast_data", rdat[i], 32'hC0DE0000 + 32'(i));

    // Missing wlast on the final beat.
    mresp = model_write(32'h140, 1, SIZE_WORD, BURST_INCR, 5);
    do_write(32'h140, 8'd1, SIZE_WORD, BURST_INCR, 4'h7, 5, 0, resp, bid_o);
    check("missing_wlast_bresp", resp, RESP_SLVERR);

    // Reset while beat 5 of an 8-beat read is on the bus.
    axi.araddr = 32'h0; axi.arlen = 8'd7; axi.arsize = SIZE_WORD; axi.arburst = BURST_INCR;
    axi.arid = 4'h9; axi.arvalid = 1'b1;
    @(negedge clk);
    axi.arvalid = 1'b0;
    axi.rready = 1'b1;
    rcount = 0;
    n = 0;
    while (rcount < 4 && n < TMO) begin
      if (axi.rvalid) rcount++;
      @(negedge clk);
      n++;
    end
    if (n >= TMO) timeout("reset_burst_beats");
    check("beat5_rdata", axi.rdata, ref_mem[4]);
    axi.rready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_rvalid", axi.rvalid, 1'b0);
    check("midrst_arready", axi.arready, 1'b1);
    check("midrst_rdata", axi.rdata, 32'h0);
    @(negedge clk);
    do_read(32'h0, 8'd7, SIZE_WORD, BURST_INCR, 4'h9, 0);
    verify_read(32'h0, 7, SIZE_WORD, BURST_INCR, 4'h9);

    // Concurrent write and read on disjoint regions.
    for (int i = 0; i < 8; i++) begin wdat[i] = $urandom; wstb[i] = 4'hF; end
    mresp = model_write(32'h200, 7, SIZE_WORD, BURST_INCR, -1);
    fork
      do_write(32'h200, 8'd7, SIZE_WORD, BURST_INCR, 4'h4, -1, 0, resp, bid_o);
      do_read(32'h3F0, 8'd3, SIZE_WORD, BURST_INCR, 4'h5, 2);
    join
    check("conc_bresp", resp, mresp);
    verify_read(32'h3F0, 3, SIZE_WORD, BURST_INCR, 4'h5);
    do_read(32'h200, 8'd7, SIZE_WORD, BURST_INCR, 4'h4, 2);
    verify_read(32'h200, 7, SIZE_WORD, BURST_INCR, 4'h4);

    // Random traffic against the model.
    for (int t = 0; t < 40; t++) begin
      logic [31:0] a = BASE + 32'($urandom_range(0, MEMW + 3)) * 32'd4 + 32'($urandom_range(0, 3));
      logic [7:0]  len = 8'($urandom_range(0, 7));
      logic [2:0]  sz = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : SIZE_WORD;
      logic [1:0]  bu = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : BURST_INCR;
      logic [3:0]  id = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) begin
        int wl = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, int'(len) + 1)) : -1;
        for (int i = 0; i <= int'(len); i++) begin wdat[i] = $urandom; wstb[i] = 4'($urandom_range(0, 15)); end
        mresp = model_write(a, int'(len), sz, bu, wl);
        do_write(a, len, sz, bu, id, wl, int'($urandom_range(0, 2)), resp, bid_o);
        check("rand_bresp", resp, mresp);
        check("rand_bid", bid_o, id);
      end else begin
        do_read(a, len, sz, bu, id, 2);
        verify_read(a, int'(len), sz, bu, id);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
